arith_csr_responder: RTL
========================

# arith_csr_responder

Memory-mapped responder between the HPS lightweight bridge and an arithmetic unit under test. It holds operands written by software and issues them to the arithmetic unit over a valid/ready handshake. It captures the double-width result, measures latency in clock cycles, and reports completion through a status register and an interrupt. It is the FPGA-side endpoint for HPS-initiated testbench transactions, clocked from `fpga_clk_50`.

## Interface
- `TIMEOUT`, 65535: maximum WAIT cycles before the operation is abandoned.
- `TIMEOUT_W`, 16: width of the cycle counter and the CYCLES field; ceil(log2(TIMEOUT+1)).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `avs_address`  in  3  word address.
- `avs_read`  in  1  read strobe, single cycle.
- `avs_write`  in  1  write strobe, single cycle.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  registered read data.
- `avs_readdatavalid`  out  1  high for one cycle, one cycle after `avs_read`.
- `dut_op_a`, `dut_op_b`  out  32  operands latched at start.
- `dut_in_valid`  out  1  operands valid.
- `dut_in_ready`  in  1  arithmetic unit accepts operands.
- `dut_res`  in  64  result.
- `dut_res_valid`  in  1  result valid, sampled in WAIT only.
- `irq`  out  1  `done & irq_en`, driven from flops.

## Operation
Register map (word address):
- 0 CTRL: write bit0 `start` (self-clearing), bit1 `clr` (clears done/err_busy/timeout), bit2 `irq_en` (stored). Read returns `{29'b0, irq_en, 2'b0}`.
- 1 STATUS, read-only: `{28'b0, timeout, err_busy, done, busy}`.
- 2 OPA, 3 OPB: R/W. Writes are always accepted; they do not affect an in-flight operation.
- 4 RES_LO / 5 RES_HI: `dut_res[31:0]` / `dut_res[63:32]`, read-only.
- 6 CYCLES: zero-extended latency of the last operation, read-only.
- 7 RUNS: 32-bit count of successful completions, wraps to 0. Any write clears it.

FSM:
- IDLE -> ISSUE on `start`. In the same edge: latch OPA/OPB into `dut_op_a/b`, clear done/timeout, clear the cycle counter.
- ISSUE: `dut_in_valid`=1. On the edge with `dut_in_valid & dut_in_ready` -> WAIT.
- WAIT: the counter increments each cycle, saturating at TIMEOUT.
  - `dut_res_valid` sampled high -> IDLE. Capture RES, set CYCLES = counter+1, set done, RUNS+1.
  - Otherwise, counter+1 == TIMEOUT -> IDLE. Set done and timeout, set CYCLES=TIMEOUT; RES and RUNS unchanged.
- `busy` = state != IDLE.

Boundary rules:
- `start` while busy: ignored; sets sticky `err_busy`.
- `clr` and `start` in the same write: clear is applied first, then start.
- Read and write in the same cycle: the write takes effect; the read returns the pre-write value.
- A read in the same cycle as completion returns the pre-completion value.
- Unused writes (STATUS, RES, CYCLES) are ignored.
- `rst_n` low mid-operation: immediately IDLE, `dut_in_valid`=0, everything cleared. A later `dut_res_valid` is ignored.

Reset values: all registers, `avs_readdata`, `avs_readdatavalid`, `dut_op_a/b`, `dut_in_valid`, `irq` = 0; state IDLE.

## Timing
- Write at edge T: the register updates at T.
  - For `start`: `busy` and `dut_in_valid` are high from T+1.
- Read sampled at edge T: `avs_readdata` and `avs_readdatavalid` are valid in the cycle after T. There are no wait states, and back-to-back reads are supported.
- If `dut_in_ready` is high in the first ISSUE cycle, the handshake takes 1 cycle; `dut_in_valid` drops the cycle after the handshake.
- If `dut_res_valid` is high in the first WAIT cycle, CYCLES=1.
- `done` and `irq` rise the cycle after the capturing edge.

## Test plan
- Reset with stimulus active -> all outputs 0; STATUS reads 0x0; RUNS reads 0.
- OPA=7, OPB=9, irq_en; start; `dut_in_ready` tied 1; stub returns 63 three cycles after the handshake -> RES_LO=63, RES_HI=0, CYCLES=3, STATUS=0x2, irq=1, RUNS=1.
- Hold `dut_in_ready` low for 5 cycles -> `dut_in_valid` held steady for 5 cycles, operands stable; CYCLES excludes the ISSUE time.
- TIMEOUT=8, `dut_res_valid` never asserted -> STATUS=0xA, CYCLES=8, RES unchanged, RUNS unchanged.
- Start while busy, then OPA write -> STATUS bit2 set; in-flight `dut_op_a` unchanged; write CTRL=0x2 -> STATUS bits 1..3 clear.
- Assert `rst_n` low during WAIT, then deliver `dut_res_valid` -> state IDLE, RES=0, done=0.

Source files
------------

// File: rtl/arith_csr_responder.sv
// Memory-mapped responder that issues software-written operands to an
// arithmetic unit over valid/ready, captures the 64-bit result, measures
// latency and reports completion through STATUS and a level interrupt.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no operation in flight; start accepted
// ISSUE  | dut_in_valid high, waiting for dut_in_ready
// WAIT   | operands accepted, counting cycles until result or timeout
module arith_csr_responder #(
    parameter int TIMEOUT   = 65535,
    parameter int TIMEOUT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic [31:0] dut_op_a,
    output logic [31:0] dut_op_b,
    output logic        dut_in_valid,
    input  logic        dut_in_ready,
    input  logic [63:0] dut_res,
    input  logic        dut_res_valid,
    output logic        irq
);

    localparam logic [TIMEOUT_W:0] TIMEOUT_EXT = (TIMEOUT_W + 1)'(TIMEOUT);
    localparam logic [TIMEOUT_W:0] ONE_EXT     = (TIMEOUT_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]          opa, opb;
    logic [63:0]          res;
    logic [TIMEOUT_W-1:0] cycles, counter;
    logic [31:0]          runs;
    logic                 irq_en, done, err_busy, timeout;
    logic                 irq_en_nxt, done_nxt, err_busy_nxt, timeout_nxt;
    logic                 wr_ctrl, start_req, clr_req, start_go;
    logic                 res_hit, tmo_hit;
    logic [TIMEOUT_W:0]   count_inc;
    logic [31:0]          rd_data;

    assign wr_ctrl   = avs_write && (avs_address == 3'd0);
    assign start_req = wr_ctrl && avs_writedata[0];
    assign clr_req   = wr_ctrl && avs_writedata[1];
    assign start_go  = start_req && (state == S_IDLE);
    assign count_inc = {1'b0, counter} + ONE_EXT;
    // A result arriving on the last allowed cycle still counts as success.
    assign res_hit   = (state == S_WAIT) && dut_res_valid;
    assign tmo_hit   = (state == S_WAIT) && !dut_res_valid && (count_inc == TIMEOUT_EXT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_go) state_nxt = S_ISSUE;
            S_ISSUE: if (dut_in_valid && dut_in_ready) state_nxt = S_WAIT;
            S_WAIT:  if (res_hit || tmo_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // dut_in_valid is registered so it tracks ISSUE from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dut_in_valid <= 1'b0;
        else        dut_in_valid <= (state_nxt == S_ISSUE);
    end

    // Status flag updates: clear before start, completion events last.
    always_comb begin
        irq_en_nxt   = irq_en;
        done_nxt     = done;
        err_busy_nxt = err_busy;
        timeout_nxt  = timeout;
        if (wr_ctrl) irq_en_nxt = avs_writedata[2];
        if (clr_req) begin
            done_nxt     = 1'b0;
            err_busy_nxt = 1'b0;
            timeout_nxt  = 1'b0;
        end
        if (start_req) begin
            if (state != S_IDLE) begin
                err_busy_nxt = 1'b1;
            end else begin
                done_nxt    = 1'b0;
                timeout_nxt = 1'b0;
            end
        end
        if (res_hit) done_nxt = 1'b1;
        if (tmo_hit) begin
            done_nxt    = 1'b1;
            timeout_nxt = 1'b1;
        end
    end

    // Flag registers; irq is built from next values so it rises with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en   <= 1'b0;
            done     <= 1'b0;
            err_busy <= 1'b0;
            timeout  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            irq_en   <= irq_en_nxt;
            done     <= done_nxt;
            err_busy <= err_busy_nxt;
            timeout  <= timeout_nxt;
            irq      <= done_nxt && irq_en_nxt;
        end
    end

    // Operand registers and the copies presented to the arithmetic unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa      <= '0;
            opb      <= '0;
            dut_op_a <= '0;
            dut_op_b <= '0;
        end else begin
            if (avs_write && avs_address == 3'd2) opa <= avs_writedata;
            if (avs_write && avs_address == 3'd3) opb <= avs_writedata;
            if (start_go) begin
                dut_op_a <= opa;
                dut_op_b <= opb;
            end
        end
    end

    // Latency counter, running only in WAIT and never passing TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
        end else if (start_go) begin
            counter <= '0;
        end else if (state == S_WAIT && count_inc < TIMEOUT_EXT) begin
            counter <= count_inc[TIMEOUT_W-1:0];
        end
    end

    // Result, latency and successful-run capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res    <= '0;
            cycles <= '0;
            runs   <= '0;
        end else begin
            if (res_hit) begin
                res    <= dut_res;
                cycles <= count_inc[TIMEOUT_W-1:0];
            end else if (tmo_hit) begin
                cycles <= TIMEOUT_EXT[TIMEOUT_W-1:0];
            end
            if (avs_write && avs_address == 3'd7) runs <= '0;
            else if (res_hit)                     runs <= runs + 32'd1;
        end
    end

    // Read mux over current (pre-update) register values.
    always_comb begin
        rd_data = '0;
        case (avs_address)
            3'd0: rd_data = {29'b0, irq_en, 2'b0};
            3'd1: rd_data = {28'b0, timeout, err_busy, done, state != S_IDLE};
            3'd2: rd_data = opa;
            3'd3: rd_data = opb;
            3'd4: rd_data = res[31:0];
            3'd5: rd_data = res[63:32];
            3'd6: rd_data = 32'(cycles);
            3'd7: rd_data = runs;
            default: rd_data = '0;
        endcase
    end

    // Registered read response, one cycle after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            avs_readdata      <= avs_read ? rd_data : 32'd0;
        end
    end

endmodule
